// File: rtl/elixirchip_es2_spu_op_mem_mp.sv
// elixirchip_es2_spu_op_mem_mp: byte-strobed write port, N independent read ports, pipelined, cke-gated
module elixirchip_es2_spu_op_mem_mp #(
    parameter int    WLATENCY   = 1,
    parameter int    RLATENCY   = 1,
    parameter int    DATA_BITS  = 8,
    parameter int    BYTE_BITS  = 8,
    parameter int    STRB_BITS  = DATA_BITS / BYTE_BITS,
    parameter int    ADDR_BITS  = 9,
    parameter int    MEM_SIZE   = 2 ** ADDR_BITS,
    parameter int    NUM_RPORTS = 2,
    parameter string RDW_MODE   = "read_first",
    parameter string MEM_TYPE   = "distributed",
    parameter string DEVICE     = "RTL",
    parameter string SIMULATION = "false",
    parameter string DEBUG      = "false"
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             cke,
    input  logic [ADDR_BITS-1:0]             s_waddr,
    input  logic [DATA_BITS-1:0]             s_wdata,
    input  logic [STRB_BITS-1:0]             s_wstrb,
    input  logic                             s_wvalid,
    input  logic [NUM_RPORTS*ADDR_BITS-1:0]  s_raddr,
    input  logic [NUM_RPORTS-1:0]            s_rvalid,
    output logic [NUM_RPORTS*DATA_BITS-1:0]  m_rdata,
    output logic [NUM_RPORTS-1:0]            m_rvalid
);
    if (DATA_BITS % BYTE_BITS != 0) begin : g_bad_byte
        $error("DATA_BITS must be a multiple of BYTE_BITS");
    end
    if (WLATENCY < 1 || RLATENCY < 1) begin : g_bad_lat
        $error("WLATENCY and RLATENCY must be >= 1");
    end
    if (NUM_RPORTS < 1 || NUM_RPORTS > 8) begin : g_bad_ports
        $error("NUM_RPORTS must be 1..8");
    end
    if (RDW_MODE != "read_first" && RDW_MODE != "write_first") begin : g_bad_rdw
        $error("RDW_MODE must be read_first or write_first");
    end
    if (MEM_TYPE != "block" && MEM_TYPE != "distributed") begin : g_bad_type
        $error("MEM_TYPE must be block or distributed");
    end
    if (DEVICE == "" || (SIMULATION != "true" && SIMULATION != "false") || (DEBUG != "true" && DEBUG != "false")) begin : g_bad_misc
        $error("DEVICE must be set, SIMULATION and DEBUG must be true or false");
    end

    localparam bit WRITE_FIRST = (RDW_MODE == "write_first");

    logic [DATA_BITS-1:0] mem [MEM_SIZE];
    logic                 c_valid;
    logic [ADDR_BITS-1:0] c_addr;
    logic [DATA_BITS-1:0] c_data;
    logic [STRB_BITS-1:0] c_strb;
    logic                 commit;

    if (WLATENCY > 1) begin : g_wpipe
        localparam int N = WLATENCY - 1;
        logic                 w_valid [N];
        logic [ADDR_BITS-1:0] w_addr  [N];
        logic [DATA_BITS-1:0] w_data  [N];
        logic [STRB_BITS-1:0] w_strb  [N];
        // shift write requests toward the commit stage; reset drops anything in flight
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < N; i++) begin
                    w_valid[i] <= 1'b0;
                    w_addr[i]  <= '0;
                    w_data[i]  <= '0;
                    w_strb[i]  <= '0;
                end
            end else if (cke) begin
                w_valid[0] <= s_wvalid;
                w_addr[0]  <= s_waddr;
                w_data[0]  <= s_wdata;
                w_strb[0]  <= s_wstrb;
                for (int i = 1; i < N; i++) begin
                    w_valid[i] <= w_valid[i-1];
                    w_addr[i]  <= w_addr[i-1];
                    w_data[i]  <= w_data[i-1];
                    w_strb[i]  <= w_strb[i-1];
                end
            end
        end
        assign c_valid = w_valid[N-1];
        assign c_addr  = w_addr[N-1];
        assign c_data  = w_data[N-1];
        assign c_strb  = w_strb[N-1];
    end else begin : g_wdirect
        assign c_valid = s_wvalid;
        assign c_addr  = s_waddr;
        assign c_data  = s_wdata;
        assign c_strb  = s_wstrb;
    end

    assign commit = reset_n && cke && c_valid && (32'(c_addr) < MEM_SIZE);

    // commit strobed bytes; the array itself is never reset
    always_ff @(posedge clk) begin
        if (commit)
            for (int b = 0; b < STRB_BITS; b++)
                if (c_strb[b]) mem[c_addr][b*BYTE_BITS +: BYTE_BITS] <= c_data[b*BYTE_BITS +: BYTE_BITS];
    end

    logic [ADDR_BITS-1:0] r_addr [NUM_RPORTS];
    logic [DATA_BITS-1:0] r_word [NUM_RPORTS];

    // word seen by each port at the sample edge; write_first folds in a same-edge commit
    always_comb begin
        for (int p = 0; p < NUM_RPORTS; p++) begin
            r_addr[p] = s_raddr[p*ADDR_BITS +: ADDR_BITS];
            r_word[p] = '0;
            if (32'(r_addr[p]) < MEM_SIZE) begin
                r_word[p] = mem[r_addr[p]];
                if (WRITE_FIRST && commit && c_addr == r_addr[p])
                    for (int b = 0; b < STRB_BITS; b++)
                        if (c_strb[b]) r_word[p][b*BYTE_BITS +: BYTE_BITS] = c_data[b*BYTE_BITS +: BYTE_BITS];
            end
        end
    end

    logic                 r_valid [NUM_RPORTS][RLATENCY];
    logic [DATA_BITS-1:0] r_data  [NUM_RPORTS][RLATENCY];

    // per-port read pipeline; data stages only load behind a valid so idle ports hold their last word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < NUM_RPORTS; p++)
                for (int s = 0; s < RLATENCY; s++) begin
                    r_valid[p][s] <= 1'b0;
                    r_data[p][s]  <= '0;
                end
        end else if (cke) begin
            for (int p = 0; p < NUM_RPORTS; p++) begin
                r_valid[p][0] <= s_rvalid[p];
                if (s_rvalid[p]) r_data[p][0] <= r_word[p];
                for (int s = 1; s < RLATENCY; s++) begin
                    r_valid[p][s] <= r_valid[p][s-1];
                    if (r_valid[p][s-1]) r_data[p][s] <= r_data[p][s-1];
                end
            end
        end
    end

    // flatten the last read stage onto the output buses
    always_comb begin
        m_rvalid = '0;
        m_rdata  = '0;
        for (int p = 0; p < NUM_RPORTS; p++) begin
            m_rvalid[p] = r_valid[p][RLATENCY-1];
            m_rdata[p*DATA_BITS +: DATA_BITS] = r_data[p][RLATENCY-1];
        end
    end
endmodule
